weight_serial_tx: RTL

Transmit side of the serial weight-load link that fills the hidden and output layer weight RAMs. On `start` it reads NUM_WEIGHTS signed weights from a parallel weight source (synchronous ROM/RAM port, one-cycle read latency). It shifts them out MSB-first as one contiguous frame on a 1-bit serial line, qualified by a write-enable strobe, which drives the `In`/`WE` inputs of the layer block. It also reports a running checksum so the host can confirm the load.

---
 rtl/weight_serial_tx.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/weight_serial_tx.sv
// Serial weight-load transmitter: fetches NUM_WEIGHTS signed weights from a
// one-cycle-latency source and shifts them out MSB-first as one gap-free frame.
module weight_serial_tx #(
    parameter int WIDTH       = 10,
    parameter int NUM_WEIGHTS = 65,
    parameter int ADDR_W      = 7
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [WIDTH-1:0]  rd_data,
    output logic              ser_out,
    output logic              we_out,
    output logic              busy,
    output logic              done,
    output logic [15:0]       checksum,
    output logic [2:0]        state_dbg
);

    localparam int BIT_W = $clog2(WIDTH);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_WAIT  = 3'd2,
        ST_SHIFT = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t            state_q;
    logic [WIDTH-1:0]  shreg_q;
    logic [BIT_W-1:0]  bitcnt_q;
    logic [ADDR_W-1:0] idx_q;
    logic [15:0]       sum_q;
    logic              rd_en_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic              ser_q;
    logic              we_q;
    logic              busy_q;
    logic              done_q;
    logic [15:0]       csum_q;

    logic [15:0]       sum_d;
    logic [ADDR_W-1:0] idx_d;
    logic              last_word;

    // Weights are signed; the host-side checksum is a 16-bit wrapping sum.
    assign sum_d     = sum_q + {{(16-WIDTH){rd_data[WIDTH-1]}}, rd_data};
    assign idx_d     = idx_q + 1'b1;
    assign last_word = (idx_q == ADDR_W'(NUM_WEIGHTS-1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            shreg_q   <= '0;
            bitcnt_q  <= '0;
            idx_q     <= '0;
            sum_q     <= '0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            ser_q     <= 1'b0;
            we_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            csum_q    <= '0;
        end else begin
            rd_en_q <= 1'b0;
            done_q  <= 1'b0;
            if (abort && state_q != ST_IDLE) begin
                state_q <= ST_IDLE;
                ser_q   <= 1'b0;
                we_q    <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                case (state_q)
                    ST_IDLE: begin
                        if (start && !abort) begin
                            state_q   <= ST_LOAD;
                            idx_q     <= '0;
                            sum_q     <= '0;
                            rd_en_q   <= 1'b1;
                            rd_addr_q <= '0;
                            busy_q    <= 1'b1;
                        end
                    end
                    ST_LOAD: state_q <= ST_WAIT;
                    ST_WAIT: begin
                        shreg_q  <= rd_data;
                        ser_q    <= rd_data[WIDTH-1];
                        we_q     <= 1'b1;
                        sum_q    <= sum_d;
                        bitcnt_q <= BIT_W'(WIDTH-1);
                        state_q  <= ST_SHIFT;
                    end
                    ST_SHIFT: begin
                        // Strobe issued here is visible in the bit-1 cycle, so the
                        // next word arrives exactly in the bit-0 cycle.
                        if (bitcnt_q == BIT_W'(2) && !last_word) begin
                            rd_en_q   <= 1'b1;
                            rd_addr_q <= idx_d;
                        end
                        if (bitcnt_q != '0) begin
                            shreg_q  <= shreg_q << 1;
                            ser_q    <= shreg_q[WIDTH-2];
                            bitcnt_q <= bitcnt_q - 1'b1;
                        end else if (last_word) begin
                            state_q <= ST_DONE;
                            ser_q   <= 1'b0;
                            we_q    <= 1'b0;
                            done_q  <= 1'b1;
                            csum_q  <= sum_q;
                        end else begin
                            shreg_q  <= rd_data;
                            ser_q    <= rd_data[WIDTH-1];
                            sum_q    <= sum_d;
                            idx_q    <= idx_d;
                            bitcnt_q <= BIT_W'(WIDTH-1);
                        end
                    end
                    ST_DONE: begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign rd_en     = rd_en_q;
    assign rd_addr   = rd_addr_q;
    assign ser_out   = ser_q;
    assign we_out    = we_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign checksum  = csum_q;
    assign state_dbg = state_q;

endmodule
